window_serializer: RTL and testbench

Parallel-to-serial converter for the HOG pixel pipeline. It accepts one packed window word of `BLOCK_WIDTH` pixels per handshake and emits the pixels one per cycle on a valid/ready stream. It is the unpacking counterpart of the kernel window shift register: it sits wherever a packed row/column window must be returned to a single-pixel stream, such as re-serialising gradient windows toward the binning stage or a debug/DMA sink.

---
 rtl/hog_stream_pkg.sv | 16 +
 rtl/window_serializer.sv | 96 +++++++++
 tb/tb_window_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hog_stream_pkg.sv
// Shared definitions for the HOG pixel stream blocks: stream FSM state
// encodings and a counter-sizing helper that never returns zero bits.
package hog_stream_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } stream_state_t;

  // Bits needed to count 0..n-1, with a floor of one bit so n==1 still
  // yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_serializer.sv
// window_serializer: unpacks one BLOCK_WIDTH-pixel window word per input
// handshake into a single-pixel valid/ready stream, LSB slice first.
// Optional macro WINDOW_SERIALIZER_MSB_FIRST_EN: emit the top slice first
// (holding register shifts left instead of right). out_last is unchanged.
module window_serializer
  import hog_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 3,
  parameter int INPUT_WIDTH = DATA_WIDTH * BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int CNT_W = clog2_min1(BLOCK_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WIDTH - 1);

  stream_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0] hold_q, hold_d;
  logic [INPUT_WIDTH-1:0] hold_shift;
  logic                   out_hs;
  logic                   in_hs;

  // Holding register after one element has been consumed; a single-element
  // word has nothing left to shift in, so it simply empties.
  generate
    if (BLOCK_WIDTH > 1) begin : g_shift
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
      assign hold_shift = {hold_q[INPUT_WIDTH-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
`else
      assign hold_shift = {{DATA_WIDTH{1'b0}}, hold_q[INPUT_WIDTH-1:DATA_WIDTH]};
`endif
    end else begin : g_noshift
      assign hold_shift = '0;
    end
  endgenerate

  // Stream outputs and handshakes; in_ready includes the same-cycle reload
  // path from out_ready so back-to-back words run without a bubble.
  always_comb begin
    out_valid = (state_q == S_SHIFT);
    out_last  = out_valid && (cnt_q == LAST_CNT);
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
    out_data  = hold_q[INPUT_WIDTH-1 -: DATA_WIDTH];
`else
    out_data  = hold_q[DATA_WIDTH-1:0];
`endif
    out_hs    = out_valid && out_ready;
    in_ready  = (state_q == S_IDLE) || (out_hs && out_last);
    in_hs     = in_valid && in_ready;
  end

  // Next-state: a load wins over the shift, which covers both the idle
  // accept and the reload on the last-element handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (in_hs) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      hold_d  = in_data;
    end else if (out_hs) begin
      hold_d = hold_shift;
      if (out_last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, counter and holding register; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer: a per-cycle vector table for the
// basic, back-to-back and backpressure streams, plus hand-written reset and
// BLOCK_WIDTH==1 sequences. Element order follows the
// WINDOW_SERIALIZER_MSB_FIRST_EN build setting.
module tb_window_serializer;

  localparam int DW = 8;
  localparam int BW = 3;
  localparam int IW = DW * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] in_data1;
  logic          in_valid1;
  logic          in_ready1;
  logic [DW-1:0] out_data1;
  logic          out_valid1;
  logic          out_ready1;
  logic          out_last1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  window_serializer #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  window_serializer #(.DATA_WIDTH(DW), .BLOCK_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1)
  );

  typedef struct {
    logic          iv;
    logic [IW-1:0] d;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          eir;
  } vec_t;

  vec_t tbl[22];

  // k-th element emitted from word w, in the configured order.
  function automatic logic [DW-1:0] el_of(input logic [IW-1:0] w, input int k);
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
    return w[(BW-1-k)*DW +: DW];
`else
    return w[k*DW +: DW];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    logic [IW-1:0] w1;
    logic [IW-1:0] w2;
    w1 = 24'h332211;
    w2 = 24'h665544;

    //          iv    d   ordy  ev  ed            el  eir
    // basic
    tbl[0]  = '{1'b1, w1, 1'b1, 1'b0, 8'h00,       1'b0, 1'b1};
    tbl[1]  = '{1'b0, w1, 1'b1, 1'b1, el_of(w1,0), 1'b0, 1'b0};
    tbl[2]  = '{1'b0, w1, 1'b1, 1'b1, el_of(w1,1), 1'b0, 1'b0};
    tbl[3]  = '{1'b0, w1, 1'b1, 1'b1, el_of(w1,2), 1'b1, 1'b1};
    tbl[4]  = '{1'b0, w1, 1'b1, 1'b0, 8'h00,       1'b0, 1'b1};
    // back-to-back
    tbl[5]  = '{1'b1, w1, 1'b1, 1'b0, 8'h00,       1'b0, 1'b1};
    tbl[6]  = '{1'b1, w2, 1'b1, 1'b1, el_of(w1,0), 1'b0, 1'b0};
    tbl[7]  = '{1'b1, w2, 1'b1, 1'b1, el_of(w1,1), 1'b0, 1'b0};
    tbl[8]  = '{1'b1, w2, 1'b1, 1'b1, el_of(w1,2), 1'b1, 1'b1};
    tbl[9]  = '{1'b0, w2, 1'b1, 1'b1, el_of(w2,0), 1'b0, 1'b0};
    tbl[10] = '{1'b0, w2, 1'b1, 1'b1, el_of(w2,1), 1'b0, 1'b0};
    tbl[11] = '{1'b0, w2, 1'b1, 1'b1, el_of(w2,2), 1'b1, 1'b1};
    tbl[12] = '{1'b0, w2, 1'b1, 1'b0, 8'h00,       1'b0, 1'b1};
    // backpressure, with in_data wiggled while not being accepted
    tbl[13] = '{1'b1, w1, 1'b0, 1'b0, 8'h00,       1'b0, 1'b1};
    tbl[14] = '{1'b0, w2, 1'b1, 1'b1, el_of(w1,0), 1'b0, 1'b0};
    tbl[15] = '{1'b0, w2, 1'b0, 1'b1, el_of(w1,1), 1'b0, 1'b0};
    tbl[16] = '{1'b1, w2, 1'b0, 1'b1, el_of(w1,1), 1'b0, 1'b0};
    tbl[17] = '{1'b0, w2, 1'b1, 1'b1, el_of(w1,1), 1'b0, 1'b0};
    tbl[18] = '{1'b0, w2, 1'b0, 1'b1, el_of(w1,2), 1'b1, 1'b0};
    tbl[19] = '{1'b1, w2, 1'b0, 1'b1, el_of(w1,2), 1'b1, 1'b0};
    tbl[20] = '{1'b0, w2, 1'b1, 1'b1, el_of(w1,2), 1'b1, 1'b1};
    tbl[21] = '{1'b0, w2, 1'b1, 1'b0, 8'h00,       1'b0, 1'b1};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'd0);
    chk("reset out_last",  32'(out_last),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready",  32'(in_ready),  32'd1);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev || i == 4 || i == 12 || i == 21)
        chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d out_last", i), 32'(out_last), 32'(tbl[i].el));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
    end

    // Reset mid-word: first element leaves, then reset drops the rest.
    @(negedge clk);
    in_valid = 1'b1; in_data = w1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("midrst first", 32'(out_data), 32'(el_of(w1, 0)));
    @(negedge clk);
    #1;
    chk("midrst second pending", 32'(out_data), 32'(el_of(w1, 1)));
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // BLOCK_WIDTH==1: one word per cycle, each element is last.
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 8'hA5; out_ready1 = 1'b1;
    #1;
    chk("bw1 idle out_valid", 32'(out_valid1), 32'd0);
    chk("bw1 idle in_ready",  32'(in_ready1),  32'd1);
    @(negedge clk);
    in_data1 = 8'h5A;
    #1;
    chk("bw1 A5 out_valid", 32'(out_valid1), 32'd1);
    chk("bw1 A5 out_data",  32'(out_data1),  32'hA5);
    chk("bw1 A5 out_last",  32'(out_last1),  32'd1);
    chk("bw1 A5 in_ready",  32'(in_ready1),  32'd1);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    chk("bw1 5A out_valid", 32'(out_valid1), 32'd1);
    chk("bw1 5A out_data",  32'(out_data1),  32'h5A);
    chk("bw1 5A out_last",  32'(out_last1),  32'd1);
    @(negedge clk);
    #1;
    chk("bw1 drained out_valid", 32'(out_valid1), 32'd0);
    chk("bw1 drained in_ready",  32'(in_ready1),  32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
